// File: rtl/act_stream_buffer.sv
// act_stream_buffer: dual-width circular activation buffer between a narrow external bus and the wide PE datapath
module act_stream_buffer #(
    parameter int DATA_SIZE  = 8,
    parameter int DEPTH      = 1024,
    parameter int EXT_WIDTH  = 32,
    parameter int INT_WIDTH  = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clear_i,
    input  logic                  ext_wr_valid_i,
    output logic                  ext_wr_ready_o,
    input  logic [EXT_WIDTH-1:0]  ext_wr_data_i,
    input  logic                  int_wr_valid_i,
    output logic                  int_wr_ready_o,
    input  logic [INT_WIDTH-1:0]  int_wr_data_i,
    input  logic                  ext_rd_valid_i,
    output logic                  ext_rd_ready_o,
    output logic [EXT_WIDTH-1:0]  ext_rd_data_o,
    output logic                  ext_rd_data_valid_o,
    input  logic                  int_rd_valid_i,
    output logic                  int_rd_ready_o,
    output logic [INT_WIDTH-1:0]  int_rd_data_o,
    output logic                  int_rd_data_valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH-1:0] head_o,
    output logic [ADDR_WIDTH-1:0] tail_o
);
    localparam int EXT_LANES = EXT_WIDTH / DATA_SIZE;
    localparam int INT_LANES = INT_WIDTH / DATA_SIZE;
    localparam int CW        = ADDR_WIDTH + 1;

    logic [DATA_SIZE-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [CW-1:0]         count, free, wr_n, rd_n;
    logic [ADDR_WIDTH-1:0] wa [INT_LANES];
    logic [ADDR_WIDTH-1:0] ra [INT_LANES];
    logic                  int_wr, ext_wr, int_rd, ext_rd;

    // Readiness from the registered count; internal side wins each direction
    always_comb begin
        free           = CW'(DEPTH) - count;
        int_wr_ready_o = !clear_i && free >= CW'(INT_LANES);
        ext_wr_ready_o = !clear_i && free >= CW'(EXT_LANES) && !int_wr_valid_i;
        int_rd_ready_o = !clear_i && count >= CW'(INT_LANES);
        ext_rd_ready_o = !clear_i && count >= CW'(EXT_LANES) && !int_rd_valid_i;
        int_wr         = int_wr_valid_i && int_wr_ready_o;
        ext_wr         = ext_wr_valid_i && ext_wr_ready_o;
        int_rd         = int_rd_valid_i && int_rd_ready_o;
        ext_rd         = ext_rd_valid_i && ext_rd_ready_o;
        wr_n           = int_wr ? CW'(INT_LANES) : ext_wr ? CW'(EXT_LANES) : '0;
        rd_n           = int_rd ? CW'(INT_LANES) : ext_rd ? CW'(EXT_LANES) : '0;
    end

    // Per-lane element addresses; natural pointer overflow gives the wrap
    always_comb begin
        for (int k = 0; k < INT_LANES; k++) begin
            wa[k] = head + ADDR_WIDTH'(k);
            ra[k] = tail + ADDR_WIDTH'(k);
        end
    end

    // Element storage; the write region is always disjoint from the read region
    always_ff @(posedge clk) begin
        if (int_wr)
            for (int k = 0; k < INT_LANES; k++)
                mem[wa[k]] <= int_wr_data_i[k*DATA_SIZE +: DATA_SIZE];
        if (ext_wr)
            for (int k = 0; k < EXT_LANES; k++)
                mem[wa[k]] <= ext_wr_data_i[k*DATA_SIZE +: DATA_SIZE];
    end

    // Pointers, occupancy and one-cycle read-data strobes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            int_rd_data_valid_o <= 1'b0;
            ext_rd_data_valid_o <= 1'b0;
        end else if (clear_i) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            int_rd_data_valid_o <= 1'b0;
            ext_rd_data_valid_o <= 1'b0;
        end else begin
            head                <= head + ADDR_WIDTH'(wr_n);
            tail                <= tail + ADDR_WIDTH'(rd_n);
            count               <= count + wr_n - rd_n;
            int_rd_data_valid_o <= int_rd;
            ext_rd_data_valid_o <= ext_rd;
        end
    end

    // Read data registers hold until the next accept on their port
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            int_rd_data_o <= '0;
            ext_rd_data_o <= '0;
        end else begin
            if (int_rd)
                for (int k = 0; k < INT_LANES; k++)
                    int_rd_data_o[k*DATA_SIZE +: DATA_SIZE] <= mem[ra[k]];
            if (ext_rd)
                for (int k = 0; k < EXT_LANES; k++)
                    ext_rd_data_o[k*DATA_SIZE +: DATA_SIZE] <= mem[ra[k]];
        end
    end

    assign count_o = count;
    assign full_o  = count == CW'(DEPTH);
    assign empty_o = count == '0;
    assign head_o  = head;
    assign tail_o  = tail;
endmodule
